// File: rtl/t_solve_pkg.sv
// Shared types for the slab-test t solver: vector payload, fixed-point format, FSM states.
// WIDTH and Q_BITS come from the `WIDTH / `Q_BITS macros when provided.
`ifndef WIDTH
`define WIDTH 32
`endif
`ifndef Q_BITS
`define Q_BITS 16
`endif

package t_solve_pkg;

  localparam int unsigned WIDTH  = `WIDTH;
  localparam int unsigned Q_BITS = `Q_BITS;
  // Dividend width: |N| needs WIDTH+1 bits, pre-shifted by Q_BITS.
  localparam int unsigned QW     = WIDTH + 1 + Q_BITS;

  localparam logic signed [WIDTH-1:0] T_MAX = {1'b0, {(WIDTH-1){1'b1}}};
  localparam logic signed [WIDTH-1:0] T_MIN = {1'b1, {(WIDTH-1){1'b0}}};

  typedef struct packed {
    logic signed [WIDTH-1:0] x;
    logic signed [WIDTH-1:0] y;
    logic signed [WIDTH-1:0] z;
  } RayDirection;

  typedef enum logic [2:0] {IDLE, LOAD, DIV, FIX, DONE} state_t;

  typedef logic [1:0] axis_t;
  localparam axis_t AXIS_X = 2'd0;
  localparam axis_t AXIS_Y = 2'd1;
  localparam axis_t AXIS_Z = 2'd2;

endpackage

// File: rtl/t_solve_fx_div_seq.sv
// Unsigned restoring divider, one quotient bit per cycle, MSB first; QW cycles after load.
// done is high during the final quotient step, so the quotient is complete on the following cycle.
module fx_div_seq
  import t_solve_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [QW-1:0]    dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [QW-1:0]    quotient
);

  localparam int unsigned CW = $clog2(QW + 1);

  logic [WIDTH-1:0] rem;
  logic [QW-1:0]    quo;
  logic [CW-1:0]    cnt;
  logic [WIDTH:0]   rem_sh;
  logic             ge;
  logic [WIDTH-1:0] diff;

  // Trial subtraction of the shifted partial remainder.
  always_comb begin
    rem_sh = {rem, quo[QW-1]};
    ge     = rem_sh >= {1'b0, divisor};
    diff   = WIDTH'(rem_sh - {1'b0, divisor});
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rem  <= '0;
      quo  <= '0;
      cnt  <= '0;
      busy <= 1'b0;
      done <= 1'b0;
    end else if (load) begin
      rem  <= '0;
      quo  <= dividend;
      cnt  <= CW'(QW);
      busy <= 1'b1;
      done <= 1'b0;
    end else if (busy) begin
      rem  <= ge ? diff : rem_sh[WIDTH-1:0];
      quo  <= {quo[QW-2:0], ge};
      cnt  <= cnt - CW'(1);
      done <= (cnt == CW'(2));
      if (cnt == CW'(1)) busy <= 1'b0;
    end else begin
      done <= 1'b0;
    end
  end

  assign quotient = quo;

endmodule

// File: rtl/t_solve.sv
// Slab-test front end: t = (P - O) / D per axis, serial x/y/z through one shared divider.
// Optional div0 output enabled by T_SOLVE_DIV0_FLAG_EN.
module t_solve
  import t_solve_pkg::*;
(
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    start,
  input  logic                    skip_in,
  input  RayDirection             RD_in,
  input  RayDirection             RO_in,
  input  RayDirection             BP_in,
  output logic                    busy,
  output logic                    valid_out,
  output logic                    skip_out,
  output logic signed [WIDTH-1:0] tx,
  output logic signed [WIDTH-1:0] ty,
  output logic signed [WIDTH-1:0] tz
`ifdef T_SOLVE_DIV0_FLAG_EN
  ,
  output logic [2:0]              div0
`endif
);

  localparam logic [QW-1:0] MAG_POS = {{(QW-WIDTH){1'b0}}, T_MAX};
  localparam logic [QW-1:0] MAG_NEG = {{(QW-WIDTH){1'b0}}, T_MIN};

  state_t                  state, state_d;
  axis_t                   axis;
  RayDirection             rd_r, ro_r, bp_r;
  logic                    sgn, dz;
  logic signed [WIDTH-1:0] hold_x, hold_y, hold_z;
`ifdef T_SOLVE_DIV0_FLAG_EN
  logic [2:0]              dz_flags;
`endif

  logic                    accept_c, load_c;
  logic signed [WIDTH-1:0] sel_d, sel_o, sel_p;
  logic [WIDTH:0]          n_c, abs_n;
  logic [WIDTH-1:0]        abs_d;
  logic [QW-1:0]           dividend;
  logic signed [WIDTH-1:0] fix_c;

  logic                    div_busy, div_done;
  logic [QW-1:0]           div_q;

  fx_div_seq u_div (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (load_c),
    .dividend (dividend),
    .divisor  (abs_d),
    .busy     (div_busy),
    .done     (div_done),
    .quotient (div_q)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_d;
  end

  // Next state; accept is blocked through the valid_out cycle.
  always_comb begin
    state_d  = state;
    accept_c = 1'b0;
    load_c   = 1'b0;
    case (state)
      IDLE: begin
        if (start && !busy && !valid_out) begin
          accept_c = 1'b1;
          if (!skip_in) state_d = LOAD;
        end
      end
      LOAD: begin
        load_c  = 1'b1;
        state_d = DIV;
      end
      DIV:     if (div_busy && div_done) state_d = FIX;
      FIX:     state_d = (axis == AXIS_Z) ? DONE : LOAD;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Operand selection, widened numerator, magnitudes, sign/saturation of the quotient.
  always_comb begin
    unique case (axis)
      AXIS_Y:  begin sel_d = rd_r.y; sel_o = ro_r.y; sel_p = bp_r.y; end
      AXIS_Z:  begin sel_d = rd_r.z; sel_o = ro_r.z; sel_p = bp_r.z; end
      default: begin sel_d = rd_r.x; sel_o = ro_r.x; sel_p = bp_r.x; end
    endcase
    n_c      = {sel_p[WIDTH-1], sel_p} - {sel_o[WIDTH-1], sel_o};
    abs_n    = n_c[WIDTH] ? -n_c : n_c;
    abs_d    = sel_d[WIDTH-1] ? WIDTH'(-sel_d) : sel_d;
    dividend = {abs_n, {Q_BITS{1'b0}}};
    if (dz)        fix_c = sgn ? T_MIN : T_MAX;
    else if (!sgn) fix_c = (div_q > MAG_POS) ? T_MAX : $signed(div_q[WIDTH-1:0]);
    else           fix_c = (div_q > MAG_NEG) ? T_MIN : -$signed(div_q[WIDTH-1:0]);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      axis      <= AXIS_X;
      rd_r      <= '0;
      ro_r      <= '0;
      bp_r      <= '0;
      sgn       <= 1'b0;
      dz        <= 1'b0;
      hold_x    <= '0;
      hold_y    <= '0;
      hold_z    <= '0;
      busy      <= 1'b0;
      valid_out <= 1'b0;
      skip_out  <= 1'b0;
      tx        <= '0;
      ty        <= '0;
      tz        <= '0;
`ifdef T_SOLVE_DIV0_FLAG_EN
      dz_flags  <= '0;
      div0      <= '0;
`endif
    end else begin
      valid_out <= 1'b0;
      if (accept_c) begin
        rd_r <= RD_in;
        ro_r <= RO_in;
        bp_r <= BP_in;
        axis <= AXIS_X;
        if (skip_in) begin
          valid_out <= 1'b1;
          skip_out  <= 1'b1;
          tx        <= '0;
          ty        <= '0;
          tz        <= '0;
`ifdef T_SOLVE_DIV0_FLAG_EN
          div0      <= '0;
`endif
        end else begin
          busy <= 1'b1;
        end
      end else if (state == IDLE) begin
        busy <= 1'b0;
      end
      if (load_c) begin
        sgn <= n_c[WIDTH] ^ sel_d[WIDTH-1];
        dz  <= (sel_d == '0);
      end
      if (state == FIX) begin
        unique case (axis)
          AXIS_Y:  hold_y <= fix_c;
          AXIS_Z:  hold_z <= fix_c;
          default: hold_x <= fix_c;
        endcase
`ifdef T_SOLVE_DIV0_FLAG_EN
        dz_flags[axis] <= dz;
`endif
        axis <= axis + 2'd1;
      end
      if (state == DONE) begin
        tx        <= hold_x;
        ty        <= hold_y;
        tz        <= hold_z;
        valid_out <= 1'b1;
        skip_out  <= 1'b0;
`ifdef T_SOLVE_DIV0_FLAG_EN
        div0      <= dz_flags;
`endif
      end
    end
  end

endmodule

// File: tb/tb_t_solve.sv
// Directed bench for t_solve (WIDTH=32, Q_BITS=16 vectors); honours T_SOLVE_DIV0_FLAG_EN.
module tb_t_solve;
  import t_solve_pkg::*;

  localparam int LAT = 3 * (QW + 2) + 1;

  logic                    clk = 1'b0;
  logic                    rst_n, start, skip_in;
  RayDirection             rd, ro, bp;
  logic                    busy, valid_out, skip_out;
  logic signed [WIDTH-1:0] tx, ty, tz;
`ifdef T_SOLVE_DIV0_FLAG_EN
  logic [2:0]              div0;
`endif

  int n_cmp = 0;
  int n_bad = 0;

  t_solve dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .skip_in   (skip_in),
    .RD_in     (rd),
    .RO_in     (ro),
    .BP_in     (bp),
    .busy      (busy),
    .valid_out (valid_out),
    .skip_out  (skip_out),
    .tx        (tx),
    .ty        (ty),
    .tz        (tz)
`ifdef T_SOLVE_DIV0_FLAG_EN
    ,
    .div0      (div0)
`endif
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic RayDirection vec(input logic [31:0] x, input logic [31:0] y, input logic [31:0] z);
    RayDirection r;
    r.x = x;
    r.y = y;
    r.z = z;
    return r;
  endfunction

  // Called just after a negedge; returns just after the accepting posedge.
  task automatic issue(input RayDirection d, input RayDirection o, input RayDirection p, input logic sk);
    rd = d; ro = o; bp = p; skip_in = sk; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  // lat = number of edges after the accept edge at which valid_out was registered.
  task automatic wait_valid(output int lat, output logic busy_ok);
    lat = 0;
    busy_ok = 1'b1;
    for (int k = 0; k < 400; k++) begin
      @(negedge clk);
      lat = k;
      if (!busy) busy_ok = 1'b0;
      if (valid_out) break;
    end
    check("valid_seen", 32'(valid_out), 32'd1);
  endtask

  task automatic run_case(input string tag, input RayDirection d, input RayDirection o,
                          input RayDirection p, input logic [31:0] ex, input logic [31:0] ey,
                          input logic [31:0] ez);
    int   lat;
    logic bok;
    @(negedge clk);
    issue(d, o, p, 1'b0);
    wait_valid(lat, bok);
    check({tag, ".lat"},  32'(lat), 32'(LAT));
    check({tag, ".busy"}, 32'(bok), 32'd1);
    check({tag, ".skip"}, 32'(skip_out), 32'd0);
    check({tag, ".tx"},   tx, ex);
    check({tag, ".ty"},   ty, ey);
    check({tag, ".tz"},   tz, ez);
    @(negedge clk);
    check({tag, ".vpulse"}, 32'(valid_out), 32'd0);
    check({tag, ".bdrop"},  32'(busy), 32'd0);
  endtask

  initial begin
    int   lat;
    logic bok;
    rst_n = 1'b0; start = 1'b0; skip_in = 1'b0;
    rd = '0; ro = '0; bp = '0;
    repeat (3) @(negedge clk);
    check("rst.busy",  32'(busy), 32'd0);
    check("rst.valid", 32'(valid_out), 32'd0);
    check("rst.skip",  32'(skip_out), 32'd0);
    check("rst.tx", tx, 32'd0);
    check("rst.ty", ty, 32'd0);
    check("rst.tz", tz, 32'd0);
`ifdef T_SOLVE_DIV0_FLAG_EN
    check("rst.div0", 32'(div0), 32'd0);
`endif
    rst_n = 1'b1;

    run_case("basic", vec(32'h0000_8000, 32'h0001_8000, 32'h0001_8000), vec(0, 0, 0),
             vec(32'h0002_0000, 32'h0003_0000, 32'hFFFD_0000),
             32'h0004_0000, 32'h0002_0000, 32'hFFFE_0000);
`ifdef T_SOLVE_DIV0_FLAG_EN
    check("basic.div0", 32'(div0), 32'd0);
`endif

    run_case("zero", vec(0, 0, 0), vec(0, 0, 0), vec(32'h0001_0000, 32'hFFFF_0000, 0),
             32'h7FFF_FFFF, 32'h8000_0000, 32'h7FFF_FFFF);
`ifdef T_SOLVE_DIV0_FLAG_EN
    check("zero.div0", 32'(div0), 32'd7);
`endif

    run_case("ovf", vec(32'h0000_0001, 32'hFFFF_FFFF, 32'hFFFE_0000), vec(0, 0, 32'hFFFF_0000),
             vec(32'h7530_0000, 32'h7530_0000, 32'h0001_0000),
             32'h7FFF_FFFF, 32'h8000_0000, 32'hFFFF_0000);

    run_case("trunc", vec(32'h0003_0000, 32'h0003_0000, 32'h0000_0002), vec(0, 32'h0001_0000, 0),
             vec(32'h0001_0000, 0, 32'hFFFF_0000),
             32'h0000_5555, 32'hFFFF_AAAB, 32'h8000_0000);

    run_case("wide", vec(32'h7FFF_FFFF, 32'h7FFF_FFFF, 32'hFFFF_0000),
             vec(32'h8000_0000, 32'h7FFF_FFFF, 5), vec(32'h7FFF_FFFF, 32'h8000_0000, 5),
             32'h0002_0000, 32'hFFFE_0000, 32'h0000_0000);

    // Skip path: immediate result, busy never rises.
    @(negedge clk);
    issue(vec(32'h0001_0000, 32'h0001_0000, 32'h0001_0000), vec(0, 0, 0),
          vec(32'h0001_0000, 32'h0001_0000, 32'h0001_0000), 1'b1);
    @(negedge clk);
    check("skip.valid", 32'(valid_out), 32'd1);
    check("skip.skip",  32'(skip_out), 32'd1);
    check("skip.busy",  32'(busy), 32'd0);
    check("skip.tx", tx, 32'd0);
    check("skip.ty", ty, 32'd0);
    check("skip.tz", tz, 32'd0);
`ifdef T_SOLVE_DIV0_FLAG_EN
    check("skip.div0", 32'(div0), 32'd0);
`endif
    skip_in = 1'b0;
    @(negedge clk);
    check("skip.vpulse", 32'(valid_out), 32'd0);
    check("skip.busy2",  32'(busy), 32'd0);

    // Back-to-back with start held high and inputs changing.
    @(negedge clk);
    rd = vec(32'h0000_8000, 32'h0001_8000, 32'h0001_8000);
    ro = vec(0, 0, 0);
    bp = vec(32'h0002_0000, 32'h0003_0000, 32'hFFFD_0000);
    skip_in = 1'b0; start = 1'b1;
    @(posedge clk);
    #1 rd = vec(32'h0001_0000, 32'h0001_0000, 32'h0001_0000);
    bp = vec(32'h0007_0000, 32'h0007_0000, 32'h0007_0000);
    wait_valid(lat, bok);
    check("b2b1.lat", 32'(lat), 32'(LAT));
    check("b2b1.tx", tx, 32'h0004_0000);
    check("b2b1.tz", tz, 32'hFFFE_0000);
    check("b2b1.busyv", 32'(busy), 32'd1);
    @(negedge clk);
    check("b2b.gapbusy", 32'(busy), 32'd0);
    check("b2b.gapvalid", 32'(valid_out), 32'd0);
    check("b2b.hold", tx, 32'h0004_0000);
    rd = vec(32'h0003_0000, 32'h0003_0000, 32'h0000_0002);
    ro = vec(0, 32'h0001_0000, 0);
    bp = vec(32'h0001_0000, 0, 32'hFFFF_0000);
    @(posedge clk);
    #1 rd = vec(32'h0001_0000, 32'h0002_0000, 32'h0004_0000);
    ro = vec(0, 0, 0);
    bp = vec(32'h0009_0000, 32'h0009_0000, 32'h0009_0000);
    wait_valid(lat, bok);
    start = 1'b0;
    check("b2b2.lat", 32'(lat), 32'(LAT));
    check("b2b2.tx", tx, 32'h0000_5555);
    check("b2b2.ty", ty, 32'hFFFF_AAAB);
    check("b2b2.tz", tz, 32'h8000_0000);

    // Reset in the middle of DIV, then an immediate new request.
    @(negedge clk);
    issue(vec(32'h0000_0001, 32'hFFFF_FFFF, 32'hFFFE_0000), vec(0, 0, 32'hFFFF_0000),
          vec(32'h7530_0000, 32'h7530_0000, 32'h0001_0000), 1'b0);
    repeat (40) @(negedge clk);
    check("abort.busy", 32'(busy), 32'd1);
    rst_n = 1'b0;
    @(negedge clk);
    check("abort.busy0",  32'(busy), 32'd0);
    check("abort.valid0", 32'(valid_out), 32'd0);
    check("abort.tx0", tx, 32'd0);
    check("abort.ty0", ty, 32'd0);
    check("abort.tz0", tz, 32'd0);
    rst_n = 1'b1;
    issue(vec(32'h7FFF_FFFF, 32'h7FFF_FFFF, 32'hFFFF_0000),
          vec(32'h8000_0000, 32'h7FFF_FFFF, 5), vec(32'h7FFF_FFFF, 32'h8000_0000, 5), 1'b0);
    wait_valid(lat, bok);
    check("abort.lat", 32'(lat), 32'(LAT));
    check("abort.tx", tx, 32'h0002_0000);
    check("abort.ty", ty, 32'hFFFE_0000);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/t_solve.md
Name: t_solve

Overview:
- Slab-test front end. Computes per-axis ray parameter t = (P - O) / D in signed Q fixed point for all three axes. Output is tx/ty/tz.
- This is the inverse operation of the dir*t multiply stage; its tx/ty/tz outputs feed that stage directly.
- One shared sequential restoring divider processes x, y, z serially. One transaction is in flight at a time, and the latency is fixed.

Parameters:
- WIDTH, `WIDTH (shared types header), total fixed-point width of all vector components and t outputs.
- Q_BITS, `Q_BITS (shared types header), number of fractional bits.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  synchronous active-low reset.
- start  in  1  request; accepted only when busy=0.
- skip_in  in  1  ray marked skip; bypasses division.
- RD_in  in  RayDirection  direction D (x, y, z, each signed WIDTH).
- RO_in  in  RayDirection  origin O.
- BP_in  in  RayDirection  slab plane P.
- busy  out  1  transaction in progress; start is ignored while high.
- valid_out  out  1  one-cycle result strobe.
- skip_out  out  1  registered skip_in of the completed transaction.
- tx, ty, tz  out  signed WIDTH  results, held until the next valid_out.

Behaviour:
- Reset: when rst_n=0 at a clock edge, all outputs return to 0 and the FSM goes to IDLE; applies mid-operation. Inputs are registered only on accept.
- Accept: a start=1 sampled in IDLE latches RD_in, RO_in, BP_in and skip_in. busy rises on the next cycle.
- Skip path: if skip_in=1 at accept, then on the next cycle valid_out=1, skip_out=1, tx=ty=tz=0, busy=0.
- Normal path, per axis, in order x, y, z:
  - LOAD (1 cycle): N = P - O computed at WIDTH+1 bits with no overflow. Latch sign = sign(N) XOR sign(D), |N| and |D|.
  - DIV (QW = WIDTH+1+Q_BITS cycles): unsigned restoring division of (|N| << Q_BITS) by |D|, one quotient bit per cycle, MSB first. Quotient is truncated toward zero.
  - FIX (1 cycle): apply the sign, then saturate to [T_MIN = -2^(WIDTH-1), T_MAX = 2^(WIDTH-1)-1]. Store the result into a holding register for the axis.
- Zero divisor (D == 0): the DIV cycles still run, so latency is unchanged. The result is forced to T_MAX if N >= 0 and T_MIN if N < 0.
- DONE: tx/ty/tz update from the holding registers. valid_out=1 for one cycle, skip_out=0, then return to IDLE.
- Latency (normal path): valid_out occurs 3*(QW+2)+1 cycles after the accept edge. Example: WIDTH=32, Q_BITS=16 gives QW=49 and latency 154.
- busy is high from the cycle after accept through the valid_out cycle inclusive. A start asserted in the valid_out cycle is not accepted.
- Holding: tx/ty/tz/skip_out keep their values between valid_out strobes and never change mid-transaction.

Optional Feature:
- Macro T_SOLVE_DIV0_FLAG_EN.
- Defined: adds output div0 [2:0] (bit0=x, bit1=y, bit2=z). A bit is set when that axis had D == 0. It updates with tx/ty/tz at valid_out, is 0 on the skip path, and is 0 after reset.
- Undefined: the port is absent and zero-divisor results are only the saturated values.

Decomposition:
- Shared types package: RayDirection (reused for origin and plane), WIDTH, Q_BITS, T_MAX/T_MIN constants, and the state enum {IDLE, LOAD, DIV, FIX, DONE} with a 2-bit axis index.
- Sub-module fx_div_seq: unsigned restoring divider with ports load / busy / done, dividend QW bits, divisor WIDTH bits, quotient QW bits. The top keeps sign handling, saturation, axis sequencing and the handshake.

Test Plan:
- Basic divide: O=0, P=(2.0, 3.0, -3.0), D=(0.5, 1.5, 1.5), Q16 -> tx=0x00040000, ty=0x00020000, tz=0xFFFE0000. valid_out exactly 154 cycles after accept, skip_out=0.
- Zero divisor: N=(1.0, -1.0, 0), D=0 on all axes -> tx=0x7FFFFFFF, tz=0x7FFFFFFF, ty=0x80000000. With the macro defined, div0=3'b111.
- Overflow: N=30000.0, D=0x00000001 -> saturated to 0x7FFFFFFF; with -D -> 0x80000000.
- Skip: start with skip_in=1 -> valid_out and skip_out on the next cycle, t outputs all 0, busy never asserts.
- Busy/back-to-back: start held high continuously with changing inputs -> only the first accept is processed. The second accept occurs in the cycle after valid_out and uses that cycle's inputs.
- Reset mid-DIV: rst_n=0 at cycle 40 of a transaction -> next cycle all outputs 0 and busy=0. No valid_out occurs for the aborted ray; a new start is accepted immediately.
